c3po_reg_bridge: RTL and testbench

Host-side bridge that sits directly upstream of the C-3PO register block. It accepts one register command at a time on a valid/ready host interface and drives the register bus (addr, rd_wr, req, write_val). It then waits for ack, captures read_val, and returns a response on a valid/ready response channel. If no port slice acks within a bounded window, the command completes with an error response, so an unmapped address can never hang the host.

---
 rtl/c3po_reg_bridge_if.sv | 34 +++
 rtl/c3po_reg_bridge.sv | 110 +++++++++++
 tb/tb_c3po_reg_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/c3po_reg_bridge_if.sv
// Host command/response channels plus the C-3PO register bus, seen from the host side (master)
// and from the bridge (slave).
interface c3po_reg_bridge_if #(
    parameter int ADDR_SIZE_P = 6
);
    logic                   host_valid;
    logic                   host_ready;
    logic                   host_rd_wr;
    logic [ADDR_SIZE_P-1:0] host_addr;
    logic [31:0]            host_wdata;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_rdata;
    logic                   rsp_err;
    logic [7:0]             timeout_cnt;

    logic [ADDR_SIZE_P-1:0] addr;
    logic                   rd_wr;
    logic                   req;
    logic [31:0]            write_val;
    logic [31:0]            read_val;
    logic                   ack;

    modport master (
        output host_valid, host_rd_wr, host_addr, host_wdata, rsp_ready, read_val, ack,
        input  host_ready, rsp_valid, rsp_rdata, rsp_err, timeout_cnt, addr, rd_wr, req, write_val
    );

    modport slave (
        input  host_valid, host_rd_wr, host_addr, host_wdata, rsp_ready, read_val, ack,
        output host_ready, rsp_valid, rsp_rdata, rsp_err, timeout_cnt, addr, rd_wr, req, write_val
    );
endinterface

// File: rtl/c3po_reg_bridge.sv
// One-outstanding host-to-register-bus bridge: req one cycle after accept, response one cycle after ack/timeout.
// Host is stalled (host_ready low) until the response is taken; a missing ack ends in an error response.
module c3po_reg_bridge #(
    parameter int ADDR_SIZE_P = 6,
    parameter int TIMEOUT_P   = 16
) (
    input  logic              clk,
    input  logic              reset,
    c3po_reg_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t                 state, state_nxt;
    logic                   accept, done_ack, done_to;
    logic [7:0]             wait_cnt;
    logic [ADDR_SIZE_P-1:0] addr_q;
    logic                   rd_wr_q;
    logic                   req_q;
    logic [31:0]            write_val_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_rdata_q;
    logic                   rsp_err_q;
    logic [7:0]             timeout_cnt_q;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.host_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // ack takes priority over a timeout landing in the same cycle
                if (bus.ack) begin
                    done_ack  = 1'b1;
                    state_nxt = RSP;
                end else if (wait_cnt == 8'(TIMEOUT_P - 1)) begin
                    done_to   = 1'b1;
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            rd_wr_q       <= 1'b0;
            req_q         <= 1'b0;
            write_val_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q      <= bus.host_addr;
                rd_wr_q     <= bus.host_rd_wr;
                write_val_q <= bus.host_wdata;
                req_q       <= 1'b1;
                wait_cnt    <= '0;
            end
            if (state == REQ && !done_ack && !done_to) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done_ack) begin
                req_q       <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= rd_wr_q ? bus.read_val : 32'd0;
            end
            if (done_to) begin
                req_q       <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= 32'd0;
                if (timeout_cnt_q != 8'hFF) begin
                    timeout_cnt_q <= timeout_cnt_q + 8'd1;
                end
            end
            if (state == RSP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.host_ready  = (state == IDLE);
    assign bus.addr        = addr_q;
    assign bus.rd_wr       = rd_wr_q;
    assign bus.req         = req_q;
    assign bus.write_val   = write_val_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.timeout_cnt = timeout_cnt_q;
endmodule

// File: tb/tb_c3po_reg_bridge.sv
// Scoreboard bench for c3po_reg_bridge: expected responses queued at command issue, popped at the response handshake.
module tb_c3po_reg_bridge;
    localparam int AW = 6;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    c3po_reg_bridge_if #(.ADDR_SIZE_P(AW)) bif ();

    c3po_reg_bridge #(.ADDR_SIZE_P(AW), .TIMEOUT_P(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ack_dly: index of the req cycle that gets ack (negative = never)
    task automatic run_cmd(input string tag, input logic rd, input logic [AW-1:0] a, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rv, input int hold, input bit next_pending);
        rsp_t       e, got;
        int         reqcyc, lat, exp_req, k;
        bit         bad, hold_bad;
        logic [7:0] to_before, to_exp;
        logic [31:0] rdata_first;
        logic        err_first;

        e.err   = (ack_dly < 0 || ack_dly >= TO);
        e.rdata = (e.err || !rd) ? 32'd0 : rv;
        exp_req = e.err ? TO : ack_dly + 1;
        sb_q.push_back(e);

        k = 0;
        while (!bif.host_ready && k < 50) begin
            tick;
            k++;
        end
        chk({tag, "_host_ready"}, 32'(bif.host_ready), 32'd1);
        to_before       = bif.timeout_cnt;
        bif.host_valid  = 1'b1;
        bif.host_rd_wr  = rd;
        bif.host_addr   = a;
        bif.host_wdata  = wd;
        bif.ack         = 1'b0;
        tick;
        bif.host_valid  = 1'b0;
        bif.host_rd_wr  = ~rd;
        bif.host_addr   = ~a;
        bif.host_wdata  = $urandom;

        reqcyc = 0;
        lat    = 1;
        bad    = 1'b0;
        while (!bif.rsp_valid && lat < 300) begin
            if (bif.req) begin
                if (bif.addr !== a || bif.rd_wr !== rd || bif.write_val !== wd) bad = 1'b1;
                bif.ack      = (reqcyc == ack_dly);
                bif.read_val = bif.ack ? rv : $urandom;
                reqcyc++;
            end
            tick;
            bif.ack      = 1'b0;
            bif.read_val = $urandom;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_req + 1);
        chk({tag, "_req_cycles"}, reqcyc, exp_req);
        chk({tag, "_bus_stable"}, 32'(bad), 32'd0);
        chk({tag, "_req_dropped"}, 32'(bif.req), 32'd0);
        to_exp = e.err ? ((to_before == 8'hFF) ? 8'hFF : to_before + 8'd1) : to_before;
        chk({tag, "_timeout_cnt"}, 32'(bif.timeout_cnt), 32'(to_exp));

        rdata_first = bif.rsp_rdata;
        err_first   = bif.rsp_err;
        hold_bad    = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (next_pending) begin
                bif.host_valid = 1'b1;
                bif.host_rd_wr = 1'($urandom);
                bif.host_addr  = AW'($urandom);
                bif.host_wdata = $urandom;
            end
            bif.ack = 1'($urandom);
            tick;
            if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== rdata_first || bif.rsp_err !== err_first ||
                bif.host_ready !== 1'b0 || bif.req !== 1'b0) hold_bad = 1'b1;
        end
        bif.ack = 1'b0;
        if (hold > 0) chk({tag, "_held_stable"}, 32'(hold_bad), 32'd0);

        bif.rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_rsp_rdata"}, bif.rsp_rdata, got.rdata);
            chk({tag, "_rsp_err"}, 32'(bif.rsp_err), 32'(got.err));
        end
        tick;
        bif.rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 32'(bif.rsp_valid), 32'd0);
        chk({tag, "_idle_again"}, 32'(bif.host_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bif.host_valid = 1'b0;
        bif.host_rd_wr = 1'b0;
        bif.host_addr  = '0;
        bif.host_wdata = '0;
        bif.rsp_ready  = 1'b0;
        bif.read_val   = '0;
        bif.ack        = 1'b0;
        repeat (3) tick;
        reset = 1'b0;

        chk("rst_req", 32'(bif.req), 32'd0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bif.rsp_rdata, 32'd0);
        chk("rst_addr", 32'(bif.addr), 32'd0);
        chk("rst_rd_wr", 32'(bif.rd_wr), 32'd0);
        chk("rst_write_val", bif.write_val, 32'd0);
        chk("rst_timeout_cnt", 32'(bif.timeout_cnt), 32'd0);
        chk("rst_host_ready", 32'(bif.host_ready), 32'd1);

        run_cmd("wr0", 1'b0, 6'd0, 32'h0000_0005, 0, 32'hDEAD_BEEF, 0, 1'b0);
        run_cmd("rd10", 1'b1, 6'd10, 32'h0, 2, 32'h0000_0013, 0, 1'b0);
        run_cmd("rd63_to", 1'b1, 6'd63, 32'h0, -1, 32'h0, 0, 1'b0);
        chk("to_count_one", 32'(bif.timeout_cnt), 32'd1);
        run_cmd("hold", 1'b1, 6'd5, 32'h0, 0, 32'h0000_A5A5, 5, 1'b1);
        run_cmd("after_hold", 1'b0, 6'd7, 32'h0000_1234, 1, 32'h0, 0, 1'b0);
        run_cmd("coinc", 1'b1, 6'd20, 32'h0, TO - 1, 32'hCAFE_F00D, 0, 1'b0);

        // stray ack while idle
        bif.ack      = 1'b1;
        bif.read_val = 32'h5555_AAAA;
        repeat (3) tick;
        bif.ack = 1'b0;
        chk("stray_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("stray_host_ready", 32'(bif.host_ready), 32'd1);
        chk("stray_req", 32'(bif.req), 32'd0);
        chk("stray_timeout_cnt", 32'(bif.timeout_cnt), 32'd1);

        // reset while in REQ
        bif.host_valid = 1'b1;
        bif.host_rd_wr = 1'b1;
        bif.host_addr  = 6'd9;
        tick;
        bif.host_valid = 1'b0;
        chk("rstreq_req_high", 32'(bif.req), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstreq_req", 32'(bif.req), 32'd0);
        chk("rstreq_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("rstreq_host_ready", 32'(bif.host_ready), 32'd1);
        chk("rstreq_timeout_cnt", 32'(bif.timeout_cnt), 32'd0);

        // reset while in RSP
        bif.host_valid = 1'b1;
        bif.host_addr  = 6'd11;
        tick;
        bif.host_valid = 1'b0;
        bif.ack        = 1'b1;
        bif.read_val   = 32'h0BAD_0BAD;
        tick;
        bif.ack = 1'b0;
        chk("rstrsp_rsp_valid_high", 32'(bif.rsp_valid), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstrsp_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("rstrsp_req", 32'(bif.req), 32'd0);
        chk("rstrsp_host_ready", 32'(bif.host_ready), 32'd1);
        tick;
        chk("rstrsp_no_late_rsp", 32'(bif.rsp_valid), 32'd0);

        run_cmd("post_rst", 1'b1, 6'd33, 32'h0, 1, 32'h7777_0001, 0, 1'b0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
